// File: rtl/amd_pkg.sv
// ----------------------------------------------------------------------------
// amd_pkg
// Shared types and constants for the gate input debounce stage.
//   dbnc_state_t : per-channel debounce FSM state
//   SYNC_STAGES  : depth of the per-channel input synchroniser
// ----------------------------------------------------------------------------
package amd_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } dbnc_state_t;

   localparam int SYNC_STAGES = 2;

endpackage : amd_pkg

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One raw asynchronous input: two-flop synchroniser, then a STABLE/CHECK
// debounce FSM that only accepts a new level after DEBOUNCE_CYCLES
// consecutive synchronised mismatches against the current clean level.
// Optional edge pulses when DEBOUNCE_EDGE_EN is defined.
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst_n     in   synchronous active-low reset
//   raw_i     in   asynchronous raw input
//   rise_o    out  one-cycle pulse with clean_o going 0->1 (DEBOUNCE_EDGE_EN)
//   fall_o    out  one-cycle pulse with clean_o going 1->0 (DEBOUNCE_EDGE_EN)
//   clean_o   out  debounced level (registered)
//   stable_o  out  1 when the FSM is in ST_STABLE (decoded from the register)
// ----------------------------------------------------------------------------
module debounce_channel
   import amd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
`ifdef DEBOUNCE_EDGE_EN
   output logic rise_o,
   output logic fall_o,
`endif
   output logic clean_o,
   output logic stable_o
);

   // Elaboration-time guards on the configuration.
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
   end
   if (CNT_W < $clog2(DEBOUNCE_CYCLES + 1)) begin : g_bad_cnt_w
      $error("debounce_channel: CNT_W too narrow to hold DEBOUNCE_CYCLES");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic                   mismatch;

   dbnc_state_t            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q,   cnt_d;
   logic                   clean_q, clean_d;

   // Plain shift chain: nothing combinational between synchroniser flops.
   assign sync     = sync_q[SYNC_STAGES-1];
   assign mismatch = (sync != clean_q);

   // NOTE: every output of a combinational block is given a default first so
   // that no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      case (state_q)
         ST_STABLE: begin
            if (!mismatch) begin
               cnt_d = '0;
            end else if (DEBOUNCE_CYCLES == 1) begin
               // A single mismatch is already enough: accept immediately.
               clean_d = sync;
            end else begin
               state_d = ST_CHECK;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_CHECK: begin
            if (!mismatch) begin
               // Input bounced back before the window closed: glitch.
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               clean_d = sync;
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   assign clean_o  = clean_q;
   assign stable_o = (state_q == ST_STABLE);

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q, fall_q;

   // Pulses are registered from the same next-state as clean_q, so they
   // coincide with the cycle in which clean_o shows its new value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= clean_d & ~clean_q;
         fall_q <= ~clean_d & clean_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;
`endif

endmodule : debounce_channel

// File: rtl/gate_input_debounce.sv
// ----------------------------------------------------------------------------
// gate_input_debounce
// Conditioning stage in front of the two-input AND gate: synchronises and
// debounces two raw asynchronous inputs and reports when both are settled.
// Optional feature macro: DEBOUNCE_EDGE_EN (adds rise_x/fall_x pulse ports).
//
// Ports
//   clk      in   clock, all state on rising edge
//   rst_n    in   synchronous active-low reset
//   raw_a    in   raw asynchronous input A
//   raw_b    in   raw asynchronous input B
//   rise_a/fall_a/rise_b/fall_b  out  one-cycle edge pulses (DEBOUNCE_EDGE_EN)
//   clean_a  out  debounced A, drives AND-gate input1
//   clean_b  out  debounced B, drives AND-gate input2
//   settled  out  1 when both channels are in ST_STABLE
// ----------------------------------------------------------------------------
module gate_input_debounce
   import amd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_a,
   input  logic raw_b,
`ifdef DEBOUNCE_EDGE_EN
   output logic rise_a,
   output logic fall_a,
   output logic rise_b,
   output logic fall_b,
`endif
   output logic clean_a,
   output logic clean_b,
   output logic settled
);

   logic stable_a, stable_b;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_chan_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw_a),
`ifdef DEBOUNCE_EDGE_EN
      .rise_o   (rise_a),
      .fall_o   (fall_a),
`endif
      .clean_o  (clean_a),
      .stable_o (stable_a)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_chan_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw_b),
`ifdef DEBOUNCE_EDGE_EN
      .rise_o   (rise_b),
      .fall_o   (fall_b),
`endif
      .clean_o  (clean_b),
      .stable_o (stable_b)
   );

   // Decoded purely from registered FSM state; no path from raw_*.
   assign settled = stable_a & stable_b;

endmodule : gate_input_debounce

// File: tb/tb_gate_input_debounce.sv
// ----------------------------------------------------------------------------
// tb_gate_input_debounce
// Drives two instances (DEBOUNCE_CYCLES=4 and =1) from the same raw inputs
// and reset. A reference model tracks, per channel, the stream of values the
// debouncer sees after the two-edge synchroniser delay; a channel flips its
// clean level when the last DEBOUNCE_CYCLES seen values all disagree with it,
// and is settled when the latest seen value agrees with it.
// ----------------------------------------------------------------------------
module tb_gate_input_debounce;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic raw_a = 1'b0;
   logic raw_b = 1'b0;

   logic clean_a4, clean_b4, settled4;
   logic clean_a1, clean_b1, settled1;
`ifdef DEBOUNCE_EDGE_EN
   logic rise_a4, fall_a4, rise_b4, fall_b4;
   logic rise_a1, fall_a1, rise_b1, fall_b1;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   gate_input_debounce #(.DEBOUNCE_CYCLES(4)) dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_a   (raw_a),
      .raw_b   (raw_b),
`ifdef DEBOUNCE_EDGE_EN
      .rise_a  (rise_a4),
      .fall_a  (fall_a4),
      .rise_b  (rise_b4),
      .fall_b  (fall_b4),
`endif
      .clean_a (clean_a4),
      .clean_b (clean_b4),
      .settled (settled4)
   );

   gate_input_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_a   (raw_a),
      .raw_b   (raw_b),
`ifdef DEBOUNCE_EDGE_EN
      .rise_a  (rise_a1),
      .fall_a  (fall_a1),
      .rise_b  (rise_b1),
      .fall_b  (fall_b1),
`endif
      .clean_a (clean_a1),
      .clean_b (clean_b1),
      .settled (settled1)
   );

   // ---------------- reference model ([dut][channel], dut0=4 cycles, dut1=1)
   int dcyc [2] = '{4, 1};
   bit dly  [2][$];          // raw samples still inside the synchroniser
   bit seen [2][$];          // values presented to the debouncer since reset
   bit m_clean  [2][2];
   bit m_stable [2][2];
   bit m_rise   [2][2];
   bit m_fall   [2][2];

   task automatic model_edge(input bit rn, input bit ra, input bit rb);
      bit r [2];
      r[0] = ra;
      r[1] = rb;
      for (int ch = 0; ch < 2; ch++) begin
         if (!rn) begin
            dly[ch].delete();
            dly[ch].push_back(1'b0);
            dly[ch].push_back(1'b0);
            seen[ch].delete();
            for (int d = 0; d < 2; d++) begin
               m_clean[d][ch]  = 1'b0;
               m_stable[d][ch] = 1'b1;
               m_rise[d][ch]   = 1'b0;
               m_fall[d][ch]   = 1'b0;
            end
         end else begin
            bit ev;
            dly[ch].push_back(r[ch]);
            ev = dly[ch].pop_front();
            seen[ch].push_back(ev);
            for (int d = 0; d < 2; d++) begin
               int n;
               bit flip;
               n    = seen[ch].size();
               flip = (n >= dcyc[d]);
               if (flip) begin
                  for (int k = 1; k <= dcyc[d]; k++)
                     if (seen[ch][n-k] == m_clean[d][ch]) flip = 1'b0;
               end
               m_rise[d][ch] = flip && !m_clean[d][ch];
               m_fall[d][ch] = flip &&  m_clean[d][ch];
               if (flip) m_clean[d][ch] = ~m_clean[d][ch];
               m_stable[d][ch] = (ev == m_clean[d][ch]);
            end
         end
      end
   endtask

   // ---------------- checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("clean_a_d4", 32'(clean_a4), 32'(m_clean[0][0]));
      check("clean_b_d4", 32'(clean_b4), 32'(m_clean[0][1]));
      check("settled_d4", 32'(settled4), 32'(m_stable[0][0] & m_stable[0][1]));
      check("clean_a_d1", 32'(clean_a1), 32'(m_clean[1][0]));
      check("clean_b_d1", 32'(clean_b1), 32'(m_clean[1][1]));
      check("settled_d1", 32'(settled1), 32'(m_stable[1][0] & m_stable[1][1]));
`ifdef DEBOUNCE_EDGE_EN
      check("rise_a_d4", 32'(rise_a4), 32'(m_rise[0][0]));
      check("fall_a_d4", 32'(fall_a4), 32'(m_fall[0][0]));
      check("rise_b_d4", 32'(rise_b4), 32'(m_rise[0][1]));
      check("fall_b_d4", 32'(fall_b4), 32'(m_fall[0][1]));
      check("rise_a_d1", 32'(rise_a1), 32'(m_rise[1][0]));
      check("fall_a_d1", 32'(fall_a1), 32'(m_fall[1][0]));
      check("rise_b_d1", 32'(rise_b1), 32'(m_rise[1][1]));
      check("fall_b_d1", 32'(fall_b1), 32'(m_fall[1][1]));
`endif
   endtask

   // One clock edge: inputs are changed only after the edge, so the values
   // captured here are the ones the DUT samples.
   task automatic step();
      bit rn, ra, rb;
      rn = rst_n;
      ra = raw_a;
      rb = raw_b;
      @(posedge clk);
      #1;
      model_edge(rn, ra, rb);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Runs n edges and reports the first edge (1-based, 0 = never) on which
   // each watched clean output is high, plus low-settled cycles of dut4.
   task automatic run_find(input int n, output int fa4, output int fb4,
                           output int fa1, output int unsettled4);
      fa4 = 0; fb4 = 0; fa1 = 0; unsettled4 = 0;
      for (int i = 1; i <= n; i++) begin
         step();
         if (fa4 == 0 && clean_a4 === 1'b1) fa4 = i;
         if (fb4 == 0 && clean_b4 === 1'b1) fb4 = i;
         if (fa1 == 0 && clean_a1 === 1'b1) fa1 = i;
         if (settled4 !== 1'b1) unsettled4++;
      end
   endtask

   initial begin
      int fa4, fb4, fa1, uns;

      // 1. Reset with both raw inputs high, then release.
      rst_n = 1'b0; raw_a = 1'b1; raw_b = 1'b1;
      run(3);
      check("reset_clean_a", 32'(clean_a4), 32'd0);
      check("reset_settled", 32'(settled4), 32'd1);
      rst_n = 1'b1;
      run_find(8, fa4, fb4, fa1, uns);
      check("release_lat_a_d4", 32'(fa4), 32'd6);
      check("release_lat_b_d4", 32'(fb4), 32'd6);
      check("release_lat_a_d1", 32'(fa1), 32'd3);
      raw_a = 1'b0; raw_b = 1'b0;
      run(8);

      // 2. Clean step on A.
      raw_a = 1'b1;
      run_find(10, fa4, fb4, fa1, uns);
      check("step_lat_a_d4", 32'(fa4), 32'd6);
      check("step_lat_a_d1", 32'(fa1), 32'd3);
      check("step_unsettled", 32'(uns), 32'd3);

      // 3. Two-cycle glitch on B.
      raw_b = 1'b1;
      run(2);
      raw_b = 1'b0;
      run(8);
      check("glitch_clean_b", 32'(clean_b4), 32'd0);
      check("glitch_settled", 32'(settled4), 32'd1);

      // 4. Boundary pulses on A: 3 cycles rejected, 4 cycles accepted.
      raw_a = 1'b0;
      run(8);
      raw_a = 1'b1;
      run_find(3, fa4, fb4, fa1, uns);
      raw_a = 1'b0;
      run_find(8, fa4, fb4, fa1, uns);
      check("pulse3_rejected", 32'(fa4), 32'd0);
      raw_a = 1'b1;
      run_find(4, fa4, fb4, fa1, uns);
      check("pulse4_not_yet", 32'(fa4), 32'd0);
      raw_a = 1'b0;
      run_find(6, fa4, fb4, fa1, uns);
      check("pulse4_accepted", 32'(fa4), 32'd2);
      run(8);

      // 5. Simultaneous rise on A and B.
      raw_a = 1'b1; raw_b = 1'b1;
      run_find(8, fa4, fb4, fa1, uns);
      check("simul_lat_a", 32'(fa4), 32'd6);
      check("simul_lat_b", 32'(fb4), 32'd6);
      check("simul_and", 32'(clean_a4 & clean_b4), 32'd1);
      raw_a = 1'b0; raw_b = 1'b0;
      run(8);

      // 6. Reset while A is in ST_CHECK with count 2.
      raw_a = 1'b1;
      run(4);
      check("midchk_unsettled", 32'(settled4), 32'd0);
      rst_n = 1'b0;
      run(1);
      check("midchk_rst_a_d4", 32'(clean_a4), 32'd0);
      check("midchk_rst_a_d1", 32'(clean_a1), 32'd0);
      rst_n = 1'b1;
      run_find(10, fa4, fb4, fa1, uns);
      check("midchk_relat_a", 32'(fa4), 32'd6);

      // 7. Random holds and occasional resets against the model.
      for (int seg = 0; seg < 120; seg++) begin
         raw_a = 1'($urandom_range(0, 1));
         raw_b = 1'($urandom_range(0, 1));
         rst_n = ($urandom_range(0, 29) != 0);
         run(int'($urandom_range(1, 7)));
      end
      rst_n = 1'b1;
      run(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_gate_input_debounce
